// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline registers and the hazard controller.
// The bundle carries the ID-stage instruction description and the controller's stall, flush and forwarding outputs.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W = 3
);
    // There is no valid/ready handshake here. The ID stage presents one instruction
    // per cycle, qualified by id_valid. The controller answers in the same cycle with
    // stall/bubble/flush/fwd, and the pipeline registers obey them on the next edge.
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_multicycle;
    logic            ex_mispredict;

    logic            stall_if;
    logic            stall_id;
    logic            flush_if_id;
    logic            bubble_ex;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            busy;
    logic [1:0]      dbg_mode;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_multicycle, ex_mispredict,
        input  stall_if, stall_id, flush_if_id, bubble_ex, fwd_a, fwd_b, busy, dbg_mode
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_multicycle, ex_mispredict,
        output stall_if, stall_id, flush_if_id, bubble_ex, fwd_a, fwd_b, busy, dbg_mode
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and sequencing controller for a 5-stage pipeline.
// It tracks the destination tags in EX/MEM/WB and a counter for multi-cycle EX ops.
module pipe_hazard_ctrl #(
    parameter int RA_W      = 3,
    parameter int MC_CYCLES = 4,
    parameter int FWD_EN    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int              MC_W    = $clog2(MC_CYCLES);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_CYCLES - 1);
    localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_BUSY   = 2'd1;
    localparam logic [1:0] MODE_FLUSH  = 2'd2;
    localparam logic [1:0] MODE_HAZARD = 2'd3;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic [RA_W-1:0] rd;
        logic            rs1_used;
        logic            rs2_used;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } ex_tag_t;

    // Downstream stages only need to know whether they write, and whether the value comes from a load.
    typedef struct packed {
        logic            wr;
        logic            memread;
        logic [RA_W-1:0] rd;
    } mem_tag_t;

    typedef struct packed {
        logic            wr;
        logic [RA_W-1:0] rd;
    } wb_tag_t;

    ex_tag_t   ex_q,  ex_d,  id_tag;
    mem_tag_t  mem_q, mem_d;
    wb_tag_t   wb_q,  wb_d;
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

    logic       ex_wr;
    logic       rs1_chk, rs2_chk;
    logic       ex_hit1, ex_hit2;
    logic       load_use, raw, hazard;
    logic [1:0] mode;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic match(input logic [RA_W-1:0] s, input logic wr,
                                   input logic [RA_W-1:0] rd);
        return wr && (s == rd) && !((ZERO_REG != 0) && (s == '0));
    endfunction

    // A load still in MEM has no result yet, so that case falls through to the older WB value.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] s, input logic used,
                                           input logic ex_valid, input mem_tag_t mem,
                                           input wb_tag_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if ((FWD_EN != 0) && ex_valid && used) begin
            if (match(s, mem.wr, mem.rd) && !mem.memread) begin
                sel = 2'b01;
            end else if (match(s, wb.wr, wb.rd)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        ex_wr    = ex_q.valid & ex_q.regwrite;
        rs1_chk  = hz.id_valid & hz.id_rs1_used;
        rs2_chk  = hz.id_valid & hz.id_rs2_used;
        ex_hit1  = match(hz.id_rs1, ex_wr, ex_q.rd);
        ex_hit2  = match(hz.id_rs2, ex_wr, ex_q.rd);
        load_use = ex_q.memread & ((rs1_chk & ex_hit1) | (rs2_chk & ex_hit2));
        raw      = (rs1_chk & (ex_hit1 | match(hz.id_rs1, mem_q.wr, mem_q.rd)
                                       | match(hz.id_rs1, wb_q.wr, wb_q.rd)))
                 | (rs2_chk & (ex_hit2 | match(hz.id_rs2, mem_q.wr, mem_q.rd)
                                       | match(hz.id_rs2, wb_q.wr, wb_q.rd)));
        hazard   = (FWD_EN != 0) ? load_use : raw;
    end

    always_comb begin
        mode = MODE_NORMAL;
        if (mc_cnt_q != '0) begin
            mode = MODE_BUSY;
        end else if (hz.ex_mispredict && ex_q.valid) begin
            mode = MODE_FLUSH;
        end else if (hazard) begin
            mode = MODE_HAZARD;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(ex_q.rs1, ex_q.rs1_used, ex_q.valid, mem_q, wb_q);
        fwd_b = fwd_sel(ex_q.rs2, ex_q.rs2_used, ex_q.valid, mem_q, wb_q);
    end

    assign hz.busy        = (mode == MODE_BUSY);
    assign hz.stall_if    = (mode == MODE_BUSY) || (mode == MODE_HAZARD);
    assign hz.stall_id    = (mode == MODE_BUSY) || (mode == MODE_HAZARD);
    assign hz.flush_if_id = (mode == MODE_FLUSH);
    assign hz.bubble_ex   = (mode == MODE_FLUSH) || (mode == MODE_HAZARD);
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.dbg_mode    = mode;

    always_comb begin
        id_tag.valid    = hz.id_valid;
        id_tag.regwrite = hz.id_regwrite;
        id_tag.memread  = hz.id_memread;
        id_tag.rd       = hz.id_rd;
        id_tag.rs1_used = hz.id_rs1_used;
        id_tag.rs2_used = hz.id_rs2_used;
        id_tag.rs1      = hz.id_rs1;
        id_tag.rs2      = hz.id_rs2;
    end

    // By default the pipeline advances one stage; only the contents that enter EX and MEM vary by mode.
    always_comb begin
        ex_d          = ex_q;
        mem_d.wr      = ex_wr;
        mem_d.memread = ex_q.valid & ex_q.memread;
        mem_d.rd      = ex_q.rd;
        wb_d.wr       = mem_q.wr;
        wb_d.rd       = mem_q.rd;
        mc_cnt_d      = mc_cnt_q;
        case (mode)
            MODE_BUSY: begin
                mem_d    = '0;
                mc_cnt_d = mc_cnt_q - MC_ONE;
            end
            MODE_FLUSH, MODE_HAZARD: begin
                ex_d = '0;
            end
            default: begin
                ex_d = id_tag;
                if (hz.id_valid && hz.id_multicycle) begin
                    mc_cnt_d = MC_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            mc_cnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end
endmodule
